uart_fifo_io: RTL

Parametrised successor UART peripheral for the 8-bit CPU register bus. Contains its own TX/RX bit engines on a single clock, plus TX and RX FIFOs of configurable depth. Adds a programmable RX interrupt threshold, FIFO level readback, flush controls and internal loopback. It sits on the same cs/rw/AD/DI/DO bus slot as existing I/O blocks and drives one level irq line.

---
 rtl/uart_fifo_io.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_io.sv
// uart_fifo_io: register-mapped UART with TX/RX FIFOs,
// RX irq threshold, level readback, flush and loopback.
module uart_fifo_io #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [15:0] PRESCALE_RST = 16'd433
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq,
  input  logic       rxd,
  output logic       txd
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [2:0] LAST = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_t;

  logic [15:0] prescale, eff;
  logic rie, tie, roe, rfe, loopback;
  logic [7:0] rx_thresh;

  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0] tx_cnt, rx_cnt;

  st_t tx_st, rx_st;
  logic [15:0] tx_tmr, tx_div, rx_tmr, rx_div;
  logic [2:0] tx_bit, rx_bit;
  logic [DATA_BITS-1:0] tx_sh, rx_sh;
  logic rx_s1, rx_s2, rx_prev;

  logic rd, wr, rx_flush, tx_flush;
  logic rx_pop, tx_pop, rx_push, tx_push;
  logic tx_end, rx_tick, rx_stop, rx_full;
  logic txe, riq, tiq;

  function automatic logic [7:0] sat8(input logic [CW-1:0] c);
    logic [15:0] w;
    w = 16'(c);
    return (w > 16'd255) ? 8'hFF : w[7:0];
  endfunction

  assign rd = cs & rw;
  assign wr = cs & ~rw;
  assign rx_flush = wr & (AD == 3'd7) & DI[0];
  assign tx_flush = wr & (AD == 3'd7) & DI[1];
  assign eff = (prescale < 16'd3) ? 16'd3 : prescale;

  assign tx_end = (tx_tmr == tx_div);
  assign tx_pop = !tx_flush && (tx_cnt != '0) &&
                  ((tx_st == IDLE) || ((tx_st == STOP) && tx_end));
  assign tx_push = wr && (AD == 3'd0) && !tx_flush &&
                   ((tx_cnt != FULL) || tx_pop);

  assign rx_pop = rd && (AD == 3'd0) && !rx_flush && (rx_cnt != '0);
  assign rx_tick = (rx_st == START) ?
                   (rx_tmr == {1'b0, rx_div[15:1]}) :
                   (rx_tmr == rx_div);
  assign rx_stop = (rx_st == STOP) && rx_tick;
  assign rx_full = (rx_cnt == FULL) && !rx_pop;
  assign rx_push = rx_stop && rx_s2 && !rx_full && !rx_flush;

  assign txe = (tx_cnt == '0) && (tx_st == IDLE);
  assign riq = rie && (16'(rx_cnt) >= 16'(rx_thresh));
  assign tiq = tie && txe;
  assign irq = riq | tiq;

  // CPU register file, read data and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      DO        <= '0;
      prescale  <= PRESCALE_RST;
      rie       <= 1'b0;
      tie       <= 1'b0;
      roe       <= 1'b0;
      rfe       <= 1'b0;
      rx_thresh <= 8'd1;
      loopback  <= 1'b0;
    end else begin
      if (rd) begin
        unique case (AD)
          3'd0: DO <= (rx_cnt != '0) ? 8'(rx_mem[rx_rp]) : 8'h00;
          3'd1: begin
            DO  <= {tiq, riq, tie, rie, txe, rfe, roe, (rx_cnt != '0)};
            roe <= 1'b0;
            rfe <= 1'b0;
          end
          3'd2: DO <= prescale[15:8];
          3'd3: DO <= prescale[7:0];
          3'd4: DO <= sat8(rx_cnt);
          3'd5: DO <= sat8(tx_cnt);
          3'd6: DO <= rx_thresh;
          3'd7: DO <= {5'b0, loopback, 2'b0};
        endcase
      end
      if (wr) begin
        unique case (AD)
          3'd1: {tie, rie} <= DI[5:4];
          3'd2: prescale[15:8] <= DI;
          3'd3: prescale[7:0] <= DI;
          3'd6: rx_thresh <= (DI == 8'd0) ? 8'd1 : DI;
          3'd7: loopback <= DI[2];
          default: ;
        endcase
      end
      if (rx_stop && !rx_s2) rfe <= 1'b1;
      if (rx_stop && rx_s2 && rx_full && !rx_flush) roe <= 1'b1;
    end
  end

  // TX FIFO pointers and occupancy; flush wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else if (tx_flush) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
    end
  end

  // RX FIFO pointers and occupancy; flush wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else if (rx_flush) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // FIFO storage arrays, contents need no reset
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= DI[DATA_BITS-1:0];
    if (rx_push) rx_mem[rx_wp] <= rx_sh;
  end

  // TX engine: start, data LSB first, stop, frames back to back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_st  <= IDLE;
      txd    <= 1'b1;
      tx_tmr <= '0;
      tx_div <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else begin
      tx_tmr <= tx_tmr + 16'd1;
      unique case (tx_st)
        IDLE: begin
          tx_tmr <= '0;
          if (tx_pop) begin
            tx_st  <= START;
            txd    <= 1'b0;
            tx_sh  <= tx_mem[tx_rp];
            tx_div <= eff;
          end
        end
        START: if (tx_end) begin
          tx_st  <= DATA;
          txd    <= tx_sh[0];
          tx_sh  <= tx_sh >> 1;
          tx_bit <= '0;
          tx_tmr <= '0;
          tx_div <= eff;
        end
        DATA: if (tx_end) begin
          tx_tmr <= '0;
          tx_div <= eff;
          if (tx_bit == LAST) begin
            tx_st <= STOP;
            txd   <= 1'b1;
          end else begin
            tx_bit <= tx_bit + 3'd1;
            txd    <= tx_sh[0];
            tx_sh  <= tx_sh >> 1;
          end
        end
        STOP: if (tx_end) begin
          tx_tmr <= '0;
          tx_div <= eff;
          if (tx_pop) begin
            tx_st <= START;
            txd   <= 1'b0;
            tx_sh <= tx_mem[tx_rp];
          end else begin
            tx_st <= IDLE;
          end
        end
      endcase
    end
  end

  // RX synchroniser and engine; loopback taps txd internally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      rx_st   <= IDLE;
      rx_tmr  <= '0;
      rx_div  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
    end else begin
      rx_s1   <= loopback ? txd : rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_tmr  <= rx_tmr + 16'd1;
      unique case (rx_st)
        IDLE: begin
          rx_tmr <= '0;
          if (rx_prev && !rx_s2) begin
            rx_st  <= START;
            rx_div <= eff;
          end
        end
        START: if (rx_tick) begin
          rx_tmr <= '0;
          rx_bit <= '0;
          rx_st  <= rx_s2 ? IDLE : DATA;
        end
        DATA: if (rx_tick) begin
          rx_tmr <= '0;
          rx_div <= eff;
          rx_sh  <= {rx_s2, rx_sh[DATA_BITS-1:1]};
          if (rx_bit == LAST) rx_st <= STOP;
          else rx_bit <= rx_bit + 3'd1;
        end
        STOP: if (rx_tick) rx_st <= IDLE;
      endcase
    end
  end

endmodule
